// File: rtl/score_calc.sv
// score_calc: turns line-clear and soft-drop events into one-cycle score
// increments for the display counter, and tracks lines cleared and level.
// Line-clear points are base x (level+1), built by repeated addition.
module score_calc #(
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 15,
    parameter int LINES_MAX       = 999
) (
    input  logic        clk_25_175,
    input  logic        reset,
    input  logic        clear_valid,
    input  logic [2:0]  clear_lines,
    output logic        clear_ready,
    input  logic        drop_valid,
    input  logic [4:0]  drop_cells,
    output logic [15:0] scorewire,
    output logic [3:0]  level,
    output logic [9:0]  lines_total,
    output logic        b2b_active
);

    localparam logic [4:0]  LPL_W   = 5'(LINES_PER_LEVEL);
    localparam logic [3:0]  LVL_MAX = 4'(MAX_LEVEL);
    localparam logic [10:0] LT_MAX  = 11'(LINES_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [15:0] acc_reg;
    logic [15:0] base_reg;
    logic [3:0]  cnt_reg;
    logic [2:0]  lines_reg;
    logic [15:0] drop_acc_reg;
    logic [3:0]  level_reg;
    logic [9:0]  lines_total_reg;
    logic        b2b_reg;
    logic [3:0]  lil_reg;

    logic        transfer;
    logic        lines_ok;
    logic        flush;
    logic        emit_enter;
    logic [15:0] base_sel;
    logic [16:0] drop_sum;
    logic [15:0] drop_next;
    logic [4:0]  lil_sum;
    logic [4:0]  lil_wrap;
    logic        level_step;
    logic [10:0] lt_sum;
    logic [9:0]  lt_next;
    logic [3:0]  level_next;

    assign level       = level_reg;
    assign lines_total = lines_total_reg;
    assign b2b_active  = b2b_reg;

    // Handshake, award selection and next-state decode.
    always_comb begin
        state_next  = state_reg;
        clear_ready = (state_reg == IDLE);
        transfer    = clear_ready && clear_valid;
        lines_ok    = (clear_lines >= 3'd1) && (clear_lines <= 3'd4);
        emit_enter  = (state_reg == MUL) && (cnt_reg == 4'd0);
        // A clear transfer wins over a pending drop flush.
        flush       = (state_reg == IDLE) && (drop_acc_reg != 16'd0) && !transfer;
        scorewire   = 16'd0;
        if (state_reg == EMIT) begin
            scorewire = acc_reg;
        end else if (flush) begin
            scorewire = drop_acc_reg;
        end
        case (state_reg)
            IDLE:    if (transfer && lines_ok) state_next = MUL;
            MUL:     if (cnt_reg == 4'd0) state_next = EMIT;
            EMIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Base points for the clear being offered; back-to-back tetris earns more.
    always_comb begin
        base_sel = 16'd0;
        case (clear_lines)
            3'd1:    base_sel = 16'd40;
            3'd2:    base_sel = 16'd100;
            3'd3:    base_sel = 16'd300;
            3'd4:    base_sel = b2b_reg ? 16'd1800 : 16'd1200;
            default: base_sel = 16'd0;
        endcase
    end

    // Saturating drop accumulator, line total and level bookkeeping.
    always_comb begin
        drop_sum   = {1'b0, (flush ? 16'd0 : drop_acc_reg)}
                   + {12'd0, (drop_valid ? drop_cells : 5'd0)};
        drop_next  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

        lt_sum     = {1'b0, lines_total_reg} + {8'd0, lines_reg};
        lt_next    = (lt_sum > LT_MAX) ? LT_MAX[9:0] : lt_sum[9:0];

        lil_sum    = {1'b0, lil_reg} + {2'b00, lines_reg};
        level_step = (lil_sum >= LPL_W);
        lil_wrap   = level_step ? (lil_sum - LPL_W) : lil_sum;
        level_next = level_reg;
        if (level_step && (level_reg < LVL_MAX)) begin
            level_next = level_reg + 4'd1;
        end
    end

    // State register; reset aborts any multiply in flight.
    always_ff @(posedge clk_25_175) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: multiplier, drop accumulator, progress counters.
    always_ff @(posedge clk_25_175) begin
        if (!reset) begin
            acc_reg         <= 16'd0;
            base_reg        <= 16'd0;
            cnt_reg         <= 4'd0;
            lines_reg       <= 3'd0;
            drop_acc_reg    <= 16'd0;
            level_reg       <= 4'd0;
            lines_total_reg <= 10'd0;
            b2b_reg         <= 1'b0;
            lil_reg         <= 4'd0;
        end else begin
            drop_acc_reg <= drop_next;

            if (transfer && lines_ok) begin
                base_reg  <= base_sel;
                acc_reg   <= 16'd0;
                cnt_reg   <= level_reg;
                lines_reg <= clear_lines;
            end

            if (state_reg == MUL) begin
                acc_reg <= acc_reg + base_reg;
                if (cnt_reg != 4'd0) begin
                    cnt_reg <= cnt_reg - 4'd1;
                end
            end

            // Counters move as the product is emitted; the new level
            // only affects the next clear.
            if (emit_enter) begin
                lines_total_reg <= lt_next;
                b2b_reg         <= (lines_reg == 3'd4);
                lil_reg         <= lil_wrap[3:0];
                level_reg       <= level_next;
            end
        end
    end

endmodule

// File: tb/tb_score_calc.sv
// Self-checking bench for score_calc: directed scenarios plus a randomized
// mix of clears, drops and idle cycles against a behavioural score model.
`timescale 1ns/1ps
module tb_score_calc;

    logic        clk_25_175 = 1'b0;
    logic        reset;
    logic        clear_valid;
    logic [2:0]  clear_lines;
    logic        clear_ready;
    logic        drop_valid;
    logic [4:0]  drop_cells;
    logic [15:0] scorewire;
    logic [3:0]  level;
    logic [9:0]  lines_total;
    logic        b2b_active;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_total_unsat;   // every valid line ever cleared since reset
    int m_lines;         // saturating total
    int m_level;
    bit m_b2b;
    int m_drop;          // points waiting to be flushed

    score_calc dut (
        .clk_25_175  (clk_25_175),
        .reset       (reset),
        .clear_valid (clear_valid),
        .clear_lines (clear_lines),
        .clear_ready (clear_ready),
        .drop_valid  (drop_valid),
        .drop_cells  (drop_cells),
        .scorewire   (scorewire),
        .level       (level),
        .lines_total (lines_total),
        .b2b_active  (b2b_active)
    );

    always #10 clk_25_175 = ~clk_25_175;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int base_pts(input int n, input bit b2b);
        case (n)
            1: return 40;
            2: return 100;
            3: return 300;
            4: return b2b ? 1800 : 1200;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_total_unsat = 0;
        m_lines = 0;
        m_level = 0;
        m_b2b = 1'b0;
        m_drop = 0;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_level"}, 32'(level), 32'(m_level));
        chk({tag, "_lines"}, 32'(lines_total), 32'(m_lines));
        chk({tag, "_b2b"}, 32'(b2b_active), 32'(m_b2b));
    endtask

    task automatic do_reset();
        @(negedge clk_25_175);
        reset = 1'b0; clear_valid = 1'b0; drop_valid = 1'b0;
        @(negedge clk_25_175);
        reset = 1'b1;
        model_reset();
        #5;
        chk("rst_sw", 32'(scorewire), 0);
        chk("rst_ready", 32'(clear_ready), 1);
        chk_status("rst");
        $display("reset: level=%0d lines=%0d b2b=%0d ready=%0d", level, lines_total, b2b_active, clear_ready);
    endtask

    task automatic idle_cycle();
        @(negedge clk_25_175);
        clear_valid = 1'b0; drop_valid = 1'b0;
        #5;
        chk("idle_ready", 32'(clear_ready), 1);
        chk("idle_sw", 32'(scorewire), 32'(m_drop));
        $display("idle: scorewire=%0d expected=%0d", scorewire, m_drop);
        m_drop = 0;
    endtask

    task automatic drop_once(input int cells);
        @(negedge clk_25_175);
        clear_valid = 1'b0; drop_valid = 1'b1; drop_cells = 5'(cells);
        #5;
        chk("drop_ready", 32'(clear_ready), 1);
        chk("drop_sw", 32'(scorewire), 32'(m_drop));
        $display("drop: cells=%0d scorewire=%0d expected=%0d", cells, scorewire, m_drop);
        m_drop = cells;   // flushed value leaves; new cells wait
    endtask

    task automatic do_clear(input int n, input bit with_drops);
        int lvl_at, prod, got;
        bit seen;
        @(negedge clk_25_175);
        clear_valid = 1'b1; clear_lines = 3'(n); drop_valid = 1'b0;
        #5;
        chk("acc_ready", 32'(clear_ready), 1);
        chk("acc_sw", 32'(scorewire), 0);
        if (n < 1 || n > 4) begin
            @(negedge clk_25_175);
            clear_valid = 1'b0;
            #5;
            chk("inv_ready", 32'(clear_ready), 1);
            chk("inv_sw", 32'(scorewire), 32'(m_drop));
            chk_status("inv");
            $display("clear lines=%0d (ignored): ready=%0d scorewire=%0d", n, clear_ready, scorewire);
            m_drop = 0;
            return;
        end
        lvl_at = m_level;
        prod = base_pts(n, m_b2b) * (lvl_at + 1);
        got = 0;
        seen = 1'b0;
        for (int k = 1; k <= lvl_at + 2; k++) begin
            @(negedge clk_25_175);
            clear_valid = 1'b0;
            clear_lines = 3'($urandom_range(0, 7));
            drop_valid = 1'b0;
            if (with_drops && lvl_at >= 1 && k <= 3) begin
                drop_valid = 1'b1;
                drop_cells = 5'($urandom_range(0, 31));
            end
            #5;
            chk("busy_ready", 32'(clear_ready), 0);
            if (k == lvl_at + 2) begin
                m_total_unsat += n;
                m_lines = (m_lines + n > 999) ? 999 : m_lines + n;
                m_level = (m_total_unsat / 10 > 15) ? 15 : m_total_unsat / 10;
                m_b2b = (n == 4);
                chk("emit_sw", 32'(scorewire), 32'(prod));
                chk_status("emit");
                got = scorewire;
                seen = 1'b1;
            end else begin
                chk("mul_sw", 32'(scorewire), 0);
            end
            if (drop_valid) begin
                m_drop = (m_drop + drop_cells > 65535) ? 65535 : m_drop + drop_cells;
            end
        end
        if (seen) begin
            $display("clear lines=%0d level=%0d: scorewire=%0d expected=%0d", n, lvl_at, got, prod);
        end
    endtask

    initial begin
        reset = 1'b0;
        clear_valid = 1'b0;
        clear_lines = 3'd0;
        drop_valid = 1'b0;
        drop_cells = 5'd0;
        model_reset();
        repeat (2) @(posedge clk_25_175);
        do_reset();

        // Single line at level 0, then tetris, back-to-back tetris, single.
        do_clear(1, 1'b0);
        chk("first_lines", 32'(lines_total), 1);
        do_clear(4, 1'b0);
        do_clear(4, 1'b0);
        chk("b2b_set", 32'(b2b_active), 1);
        do_clear(1, 1'b0);
        chk("b2b_clr", 32'(b2b_active), 0);
        do_clear(0, 1'b0);
        idle_cycle();

        // Ten singles to reach level 1; the eleventh earns 80 and carries drops.
        do_reset();
        for (int i = 0; i < 10; i++) do_clear(1, 1'b0);
        chk("lvl_after10", 32'(level), 1);
        do_clear(1, 1'b1);
        idle_cycle();   // accumulated drop points flushed here
        idle_cycle();   // then nothing

        // Randomized mix against the model.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0, 1: do_clear($urandom_range(0, 7), 1'($urandom_range(0, 1)));
                2:    drop_once($urandom_range(1, 31));
                default: idle_cycle();
            endcase
        end
        idle_cycle();

        // Reset during the multiply of a level-3 tetris.
        do_reset();
        for (int i = 0; i < 8; i++) do_clear(4, 1'b0);
        chk("lvl3", 32'(level), 3);
        @(negedge clk_25_175);
        clear_valid = 1'b1; clear_lines = 3'd4;
        @(negedge clk_25_175);
        clear_valid = 1'b0;
        #5;
        chk("mid_busy", 32'(clear_ready), 0);
        @(negedge clk_25_175);
        reset = 1'b0;
        #5;
        chk("mid_rst_sw", 32'(scorewire), 0);
        @(negedge clk_25_175);
        reset = 1'b1;
        model_reset();
        #5;
        chk("post_rst_ready", 32'(clear_ready), 1);
        chk("post_rst_sw", 32'(scorewire), 0);
        chk_status("post_rst");
        for (int i = 0; i < 6; i++) idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/score_calc.md
Name: score_calc

Overview:
- Upstream stage of the score display. Converts game events into one-cycle `scorewire` increments that the display's digit counter consumes.
- Game events are line-clear reports from the playfield and soft-drop cell counts.
- Computes classic line-clear points multiplied by (level+1), with a back-to-back tetris bonus.
- Tracks lines cleared and the current level.
- Multiplication is a multi-cycle repeated add, so clears use a valid/ready handshake.

Parameters:
- LINES_PER_LEVEL, 10, lines needed to advance one level (legal range 5..15).
- MAX_LEVEL, 15, saturation value of `level`.
- LINES_MAX, 999, saturation value of `lines_total`.

Ports:
- clk_25_175  in  1  pixel/system clock.
- reset  in  1  synchronous, active-low reset.
- clear_valid  in  1  line-clear event present; held by the source until accepted.
- clear_lines  in  3  number of lines cleared (1..4 legal).
- clear_ready  out  1  high when a clear can be accepted.
- drop_valid  in  1  one-cycle soft-drop report.
- drop_cells  in  5  cells dropped (points = cells).
- scorewire  out  16  points to add; non-zero for exactly one cycle per award, else 0.
- level  out  4  current level, 0..MAX_LEVEL.
- lines_total  out  10  total lines cleared, saturating at LINES_MAX.
- b2b_active  out  1  last scoring clear was a tetris.

Behaviour:
- Reset (one clock edge with reset=0) drives all outputs and state to zero:
  - `scorewire`=0, `level`=0, `lines_total`=0, `b2b_active`=0.
  - Internal drop_acc=0, state=IDLE.
  - `clear_ready`=1 in the first cycle after reset.
- Reset mid-operation aborts MUL/EMIT without emitting anything.
- `clear_ready` = (state==IDLE). A transfer occurs on an edge where clear_valid && clear_ready.
- clear_lines of 0, 5, 6 or 7:
  - The transfer still completes (clear_ready stays high).
  - No score, no line count, `b2b_active` unchanged.
- Base points for lines 1/2/3/4: 40/100/300/1200. The base is 1800 when lines==4 and `b2b_active`==1.
- FSM states:
  - IDLE: on transfer, load base, acc=0, cnt=level; go to MUL.
  - MUL: acc += base each cycle. When cnt==0, go to EMIT; else cnt--. This gives level+1 adds.
  - EMIT: for one cycle, `scorewire`=acc. In the same edge that enters EMIT:
    - `lines_total` += lines, saturating.
    - `b2b_active` <= (lines==4).
    - Level update (below).
    - Next state IDLE.
- Timing: with level L, `scorewire` carries the product in the (L+2)th cycle after the accepting edge. `clear_ready` is low from the accepting edge through that cycle and high the cycle after.
- Width rule: the maximum product is 1800×16 = 28800, which fits in 16 bits with no overflow. acc is 16-bit.
- Level tracking:
  - An internal lines_in_level counter (0..LINES_PER_LEVEL-1) adds k lines.
  - If the sum is ≥ LINES_PER_LEVEL: subtract LINES_PER_LEVEL and level++, saturating at MAX_LEVEL.
  - At most one level step per clear, since k≤4 < LINES_PER_LEVEL.
  - The new level applies to the next clear, not the current one.
- Drop handling:
  - drop_valid adds drop_cells into a 16-bit drop_acc that saturates at 16'hFFFF. Accumulation happens in every state.
  - Flush happens in IDLE when drop_acc≠0 and no clear transfer occurs on that edge. The flush drives `scorewire`=drop_acc for one cycle.
  - On a flush, drop_acc becomes drop_cells if drop_valid is high on the same edge, else 0. No points are lost.
  - A clear transfer in IDLE takes priority over a drop flush. The flush waits until IDLE is re-entered.
  - EMIT and a flush never coincide, so `scorewire` never carries a sum of two awards.
- `scorewire` is 0 in every cycle that is not an EMIT or flush cycle.

Test Plan:
- Reset, then clear_lines=1 at level 0:
  - clear_ready drops for 2 cycles.
  - scorewire=40 (0x0028) for one cycle, 2 cycles after accept.
  - lines_total=1, level=0.
- Two consecutive tetrises at level 0:
  - First gives scorewire=1200 and b2b_active=1.
  - Second gives scorewire=1800.
  - A following 1-line clear gives 40 and b2b_active=0.
- Ten single-line clears:
  - level=1 after the 10th.
  - The 11th clear gives scorewire=80, with clear_ready low for 3 cycles.
- Drive drop_valid with drop_cells=5, 7, 3 during a MUL phase:
  - The EMIT award appears alone.
  - Next cycle scorewire=15.
  - Then 0.
- clear_lines=0 with clear_valid:
  - Accepted in one cycle.
  - scorewire stays 0; lines_total and b2b_active unchanged.
- Reset asserted during MUL of a level-3 tetris:
  - No scorewire pulse.
  - All outputs 0 and clear_ready=1 after release.
